muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting beside the ALU in the execute stage. Consumes the two source operands read from the register file plus the decoded funct3, computes over a fixed multi-cycle latency, and presents a result with its destination register id for the register file write port. Fixed latency for all eight M-extension ops keeps hazard tracking in the pipeline control simple.

## Interface
- No parameters; data width fixed at 32 (uint32), register id is regId_t (5 bits).
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when unit is idle (busy=0)
- kill  in  1  abort in-flight op (pipeline flush)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  32  operand A (uint32)
- rs2_data  in  32  operand B (uint32)
- rd  in  5  destination register id (regId_t), captured with start
- busy  out  1  op in flight; new start ignored
- done  out  1  one-cycle pulse, result/result_rd valid
- result  out  32  op result; held until next accepted op's done
- result_rd  out  5  rd captured at start, held like result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and kill=0 → latch funct3, rd, operands; compute sign flags and magnitudes; iteration counter ← 0; go CALC.
- Sign rules: MUL/MULH/DIV/REM both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU both unsigned. Magnitude = two's-complement negation of negative signed operand.
- CALC, multiply: unsigned shift-add of magnitudes into 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
- CALC, divide: restoring division of magnitudes, one quotient bit per cycle, 32 cycles; 33-bit partial remainder.
- FIX (1 cycle): apply signs and select result, register into result.
  - MUL: low 32 of signed product; MULH/MULHSU/MULHU: high 32. Product negated iff sign(A) xor sign(B) under op's sign rules.
  - DIV: quotient negated iff sign(A) xor sign(B); REM: remainder takes sign of A.
  - Divisor zero (all div ops): quotient = 0xFFFFFFFF, remainder = rs1_data unmodified.
  - DIV/REM overflow (A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Falls out of magnitude path; must be verified, not special-cased required.
- DONE: done=1 for exactly this cycle; return to IDLE. result/result_rd updated on entering DONE and held afterward.
- rd = 0 computed normally; register file discards the write.
- kill=1 in any non-IDLE state → IDLE next edge, no done, result/result_rd unchanged. kill=1 in IDLE with start=1 → start ignored. kill during DONE cycle: done already visible, not retracted.
- start while busy=1: ignored, no queueing.

## Timing
- Reset (async): state IDLE, busy=0, done=0, result=0, result_rd=0, counter=0.
- start sampled high in cycle 0 → busy=1 cycles 1–33 (CALC 1–32, FIX 33) → done=1, busy=0 in cycle 34.
- Fixed 34-cycle start-to-done latency for every op, including divide-by-zero and overflow.
- Back-to-back: start may be asserted during the DONE cycle (busy=0); accepted, next done in cycle 68.
- busy is registered; done is a registered state decode, no combinational path from inputs to outputs.
- Reset asserted mid-op: immediate clear to reset values, no done.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → done exactly 34 cycles after start, result=0xFFFFFFEB, result_rd=5; busy high cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5; overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- start held high throughout op with changing operands → ignored while busy; second op accepted in DONE cycle, its done at cycle 68 with correct value.
- kill at cycle 10 → IDLE, no done, result retains previous value; async rst at cycle 20 → all outputs 0 immediately, no done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Every operation takes exactly 34 cycles from accepted start to the done pulse.
// Multiplies use a shift-add loop on operand magnitudes, one bit per cycle.
// Divides use a restoring loop on operand magnitudes, one bit per cycle.
// Signs are applied in a single fix-up cycle before the result is registered.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Two's-complement negation when en is set.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  // Control state (reset).
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  result_rd_q, result_rd_d;

  // Datapath state (no reset needed; always loaded on accept).
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  // m: multiplicand (multiply) or divisor (divide).
  logic [31:0] m_q, m_d;
  // hi: upper product half or partial remainder.
  logic [31:0] hi_q, hi_d;
  // lo: multiplier bits or dividend, which becomes the quotient.
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] prod;

  // Operand sign decode and magnitude formation for the incoming request.
  always_comb begin
    a_signed = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV) || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
               (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_neg    = a_signed & rs1_data[31];
    b_neg    = b_signed & rs2_data[31];
    a_mag    = cond_neg32(rs1_data, a_neg);
    b_mag    = cond_neg32(rs2_data, b_neg);
    // DONE behaves like IDLE for acceptance so ops can run back to back.
    accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !kill;
  end

  // Sequencer: next state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_CALC;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = kill ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration datapath: operand capture, one shift-add or restoring step per CALC cycle.
  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    rem_sh  = {hi_q, lo_q[31]};
    rem_ge  = (rem_sh >= {1'b0, m_q});
    // When rem_ge holds, the difference is below the divisor and fits in 32 bits.
    rem_sub = rem_sh[31:0] - m_q;
    if (accept) begin
      op_d = funct3;
      rd_d = rd;
      sa_d = a_neg;
      sb_d = b_neg;
      bz_d = (rs2_data == 32'd0);
      hi_d = 32'd0;
      if (funct3[2]) begin
        m_d  = b_mag;
        lo_d = a_mag;
      end else begin
        m_d  = a_mag;
        lo_d = b_mag;
      end
    end else if (state_q == ST_CALC) begin
      if (op_q[2]) begin
        hi_d = rem_ge ? rem_sub : rem_sh[31:0];
        lo_d = {lo_q[30:0], rem_ge};
      end else begin
        hi_d = mul_sum[32:1];
        lo_d = {mul_sum[0], lo_q[31:1]};
      end
    end
  end

  // Fix-up: apply signs, select the half or quotient/remainder, register on entering DONE.
  always_comb begin
    result_d    = result_q;
    result_rd_d = result_rd_q;
    prod        = cond_neg64({hi_q, lo_q}, sa_q ^ sb_q);
    if ((state_q == ST_FIX) && !kill) begin
      result_rd_d = rd_q;
      case (op_q)
        OP_MUL:                     result_d = prod[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[63:32];
        OP_DIV:                     result_d = bz_q ? 32'hFFFF_FFFF : cond_neg32(lo_q, sa_q ^ sb_q);
        OP_DIVU:                    result_d = bz_q ? 32'hFFFF_FFFF : lo_q;
        OP_REM:                     result_d = cond_neg32(hi_q, sa_q);
        default:                    result_d = hi_q;
      endcase
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      result_q    <= 32'd0;
      result_rd_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    rd_q <= rd_d;
    sa_q <= sa_d;
    sb_q <= sb_d;
    bz_q <= bz_d;
    m_q  <= m_d;
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_rd = result_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors with literal expectations,
// plus a cycle-by-cycle arithmetic reference model of timing and results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .busy(busy), .done(done), .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference result from plain 64-bit arithmetic and the M-extension rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as_, au, bs, bu, p;
    as_ = {{32{a[31]}}, a};
    au  = {32'd0, a};
    bs  = {{32{b[31]}}, b};
    bu  = {32'd0, b};
    case (f)
      3'b000: begin p = as_ * bs; return p[31:0];  end
      3'b001: begin p = as_ * bs; return p[63:32]; end
      3'b010: begin p = as_ * bu; return p[63:32]; end
      3'b011: begin p = au * bu;  return p[63:32]; end
      3'b100: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = as_ / bs; return p[31:0]; end
      3'b101: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = au / bu;  return p[31:0]; end
      3'b110: begin if (b == 32'd0) return a; p = as_ % bs; return p[31:0]; end
      default: begin if (b == 32'd0) return a; p = au % bu; return p[31:0]; end
    endcase
  endfunction

  // Compare process: reference timing/result model checked every cycle.
  bit          pend = 1'b0;
  int          pend_start = 0;
  int          pend_done = 0;
  logic [31:0] pend_res = 32'd0;
  logic [4:0]  pend_rd = 5'd0;
  logic [31:0] exp_res = 32'd0;
  logic [4:0]  exp_rd = 5'd0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst result", result, 0);
      chk("rst result_rd", result_rd, 0);
      pend    = 1'b0;
      exp_res = 32'd0;
      exp_rd  = 5'd0;
    end else begin
      if (pend && ncyc == pend_done) begin
        exp_res = pend_res;
        exp_rd  = pend_rd;
      end
      chk("cyc done", done, (pend && ncyc == pend_done) ? 1 : 0);
      chk("cyc busy", busy, (pend && ncyc > pend_start && ncyc < pend_done) ? 1 : 0);
      chk("cyc result", result, exp_res);
      chk("cyc result_rd", result_rd, exp_rd);
      if (pend && ncyc == pend_done) pend = 1'b0;
      else if (pend && kill) pend = 1'b0;
      if (!pend && start && !kill) begin
        pend       = 1'b1;
        pend_start = ncyc;
        pend_done  = ncyc + 34;
        pend_res   = model(funct3, rs1_data, rs2_data);
        pend_rd    = rd;
      end
    end
  end

  // Issue one op, wait (bounded) for done, check latency and literal result.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    int s;
    bit seen;
    chk({name, " model"}, model(f, a, b), exp);
    @(posedge clk); #1;
    funct3 = f; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
    s = ncyc;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({name, " latency"}, seen ? (ncyc - s) : -1, 34);
    chk({name, " result"}, result, exp);
    chk({name, " result_rd"}, result_rd, r);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int s;
    int dcnt;
    bit seen;

    #1 rst = 1'b1;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset result_rd", result_rd, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    run_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("MULH min*min",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000);
    run_op("MULHU max*max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
    run_op("MULH 2^16*2^16", 3'b001, 32'h0001_0000,  32'h0001_0000, 5'd9,  32'h0000_0001);
    run_op("MUL rd0",        3'b000, 32'h0001_0000,  32'h0001_0000, 5'd0,  32'h0000_0000);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF);
    run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,         5'd12, 32'd14);
    run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,         5'd13, 32'd2);
    run_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF);
    run_op("REM 5/0",        3'b110, 32'd5,          32'd0,         5'd15, 32'd5);
    run_op("DIV -7/0",       3'b100, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFFF);
    run_op("REM -7/0",       3'b110, 32'hFFFF_FFF9,  32'd0,         5'd17, 32'hFFFF_FFF9);
    run_op("DIV ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
    run_op("REM ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'd0);

    // start held high with changing operands; second op accepted in the DONE cycle.
    @(posedge clk); #1;
    funct3 = 3'b000; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd = 5'd5; start = 1'b1;
    s = ncyc;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      if (k < 34) begin
        funct3   = 3'($urandom_range(7));
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd       = 5'($urandom_range(31));
      end else begin
        chk("held first done", done, 1);
        chk("held first result", result, 32'hFFFF_FFEB);
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd9;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("b2b latency", seen ? (ncyc - s) : -1, 68);
    chk("b2b result", result, 32'd14);
    chk("b2b result_rd", result_rd, 5'd9);

    // Kill at cycle 10: no done, previous result retained.
    run_op("MUL pre-kill", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill busy", busy, 0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("kill no done", dcnt, 0);
    chk("kill result", result, 32'hFFFF_FFEB);
    chk("kill result_rd", result_rd, 5'd5);

    // kill with start in idle: request ignored.
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd = 5'd4;
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("kill+start busy", busy, 0);
    @(posedge clk); #1;

    // Asynchronous reset at cycle 20 of an op.
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("pre-rst busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midop rst busy", busy, 0);
    chk("midop rst done", done, 0);
    chk("midop rst result", result, 0);
    chk("midop rst result_rd", result_rd, 0);
    @(posedge clk); #1 rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("rst no done", dcnt, 0);

    run_op("MULHU post-rst", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'h0000_0001);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
